// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor bypasses iteration and reports saturated quotient with div_by_zero.
module divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [WIDTH-1:0] dvd_next, rem_next;
    logic [WIDTH:0]   partial, diff;
    logic [CW-1:0]    count;
    logic             q_bit, start, last, zero_div;

    // dvd shifts the dividend out at the top while quotient bits fill in from the bottom
    always_comb begin
        partial  = {rem, dvd[WIDTH-1]};
        diff     = partial - {1'b0, dvs};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        dvd_next = (dvd << 1) | WIDTH'(q_bit);
    end

    assign start    = enable && (state == IDLE || state == DONE);
    assign last     = (count == LAST);
    assign zero_div = (divisor == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = zero_div ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (enable) state_next = zero_div ? DONE : RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            rem         <= '0;
            count       <= '0;
            div_by_zero <= zero_div;
            if (zero_div) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            dvd   <= dvd_next;
            rem   <= rem_next;
            count <= count + 1'b1;
            // results publish on the same edge that enters DONE
            if (last) begin
                quotient  <= dvd_next;
                remainder <= rem_next;
            end
        end
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: start request, sampled on the rising clock edge.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator.
REQ-007 SHALL have port quotient, output, WIDTH bits: registered result.
REQ-008 SHALL have port remainder, output, WIDTH bits: registered result.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-011 SHALL have port div_by_zero, output, 1 bit: high with done when divisor was 0.

Function
REQ-012 SHALL have three states: IDLE, RUN and DONE.
REQ-013 SHALL accept a start on a rising edge where enable=1 and the state is IDLE or DONE; that edge is the start edge.
REQ-014 SHALL latch dividend and divisor on the start edge; later input changes SHALL NOT affect the operation in flight.
REQ-015 SHALL ignore enable while in RUN, with no restart and no queued request.
REQ-016 SHALL, for a nonzero divisor, move to RUN on the start edge and perform unsigned restoring division at one quotient bit per cycle, MSB first, with a (WIDTH+1)-bit partial remainder.
REQ-017 SHALL keep busy=1 for exactly WIDTH cycles after the start edge and SHALL move to DONE on the WIDTH-th edge after the start edge.
REQ-018 SHALL update quotient and remainder on entry to DONE, raise done=1 for exactly one cycle, and hold busy=0 while in DONE.
REQ-019 SHALL guarantee the results satisfy quotient*divisor+remainder=dividend and remainder<divisor.
REQ-020 SHALL, for divisor=0, move from the start edge directly to DONE, with busy never asserted, and output quotient=all ones, remainder=dividend, div_by_zero=1 and done=1.
REQ-021 SHALL clear div_by_zero on the next start edge; otherwise it SHALL be held.
REQ-022 SHALL hold quotient and remainder stable after DONE until the next DONE entry, including through RUN of a following operation.
REQ-023 SHALL move from DONE to IDLE on the next edge when enable=0, and back to RUN (or to DONE for a zero divisor) when enable=1, so back-to-back operations need no idle cycle.
REQ-024 SHALL keep the iteration counter width at ceil(log2(WIDTH+1)) bits; the counter SHALL NOT wrap within an operation.
REQ-025 SHALL produce correct results for dividend=0, for divisor=1, and for dividend<divisor (quotient=0, remainder=dividend).

Reset
REQ-026 SHALL, on reset_n=0 and independent of clock, force the state to IDLE and set quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, with counter and operand registers cleared.
REQ-027 SHALL, on reset asserted mid-RUN, abort the operation and never produce done for it.
REQ-028 SHALL, after reset_n rises, require a fresh start edge before any operation begins.

Verification
REQ-029 Bench SHALL check basic division (WIDTH=8): start with 100/7 -> busy high for 8 cycles, done on the 8th edge after the start edge, quotient=14, remainder=2, div_by_zero=0.
REQ-030 Bench SHALL check divide by zero: start with 37/0 -> done 1 edge after the start edge, busy never high, quotient=255, remainder=37, div_by_zero=1.
REQ-031 Bench SHALL check boundary operands: 255/1 -> 255 rem 0; 255/255 -> 1 rem 0; 5/9 -> 0 rem 5; 0/3 -> 0 rem 0.
REQ-032 Bench SHALL check start protection and back-to-back: start 200/13; toggle enable and change operands during RUN -> result is 15 rem 5; hold enable=1 in the DONE cycle with 81/9 -> second done 8 cycles later with quotient=9, remainder=0.
REQ-033 Bench SHALL check reset mid-operation: assert reset_n=0 at cycle 4 of RUN -> all outputs 0 immediately, no done pulse; after release, 50/6 -> 8 rem 2.
REQ-034 Bench SHALL run an exhaustive sweep for WIDTH=4: all 256 operand pairs, checking REQ-019 for every pair, or REQ-020 where divisor=0.
